// File: rtl/jtkcpu_regs_pkg.sv
// rtl/jtkcpu_regs_pkg.sv - shared JTKCPU register codes, CC bit indices and register-file helpers
//
// Contents:
//   REG_*        register select codes used by src_sel/dst_sel
//   CC_*         bit positions inside the CC register {E,F,H,I,N,Z,V,C}
//   CC_RESET     CC value after reset (F and I set)
//   regs_t       packed bundle of the architectural registers
//   reg_rd       read a register by code, 8-bit registers zero-extended
//   reg_wr       write a 16-bit value to a register by code
package jtkcpu_regs_pkg;

    localparam logic [3:0] REG_D  = 4'd0;
    localparam logic [3:0] REG_X  = 4'd1;
    localparam logic [3:0] REG_Y  = 4'd2;
    localparam logic [3:0] REG_U  = 4'd3;
    localparam logic [3:0] REG_S  = 4'd4;
    localparam logic [3:0] REG_A  = 4'd8;
    localparam logic [3:0] REG_B  = 4'd9;
    localparam logic [3:0] REG_CC = 4'd10;
    localparam logic [3:0] REG_DP = 4'd11;

    localparam int CC_C = 0;
    localparam int CC_V = 1;
    localparam int CC_Z = 2;
    localparam int CC_N = 3;
    localparam int CC_I = 4;
    localparam int CC_H = 5;
    localparam int CC_F = 6;
    localparam int CC_E = 7;

    localparam logic [7:0] CC_RESET = 8'h50;

    typedef struct packed {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] u;
        logic [15:0] s;
        logic [7:0]  dp;
        logic [7:0]  cc;
    } regs_t;

    localparam regs_t REGS_RESET = '{
        a: 8'h00, b: 8'h00, x: 16'h0000, y: 16'h0000,
        u: 16'h0000, s: 16'h0000, dp: 8'h00, cc: CC_RESET
    };

    function automatic logic [15:0] reg_rd(input regs_t r, input logic [3:0] code);
        logic [15:0] v;
        v = 16'h0000;
        case (code)
            REG_D:   v = {r.a, r.b};
            REG_X:   v = r.x;
            REG_Y:   v = r.y;
            REG_U:   v = r.u;
            REG_S:   v = r.s;
            REG_A:   v = {8'h00, r.a};
            REG_B:   v = {8'h00, r.b};
            REG_CC:  v = {8'h00, r.cc};
            REG_DP:  v = {8'h00, r.dp};
            default: v = 16'h0000;
        endcase
        return v;
    endfunction

    // 8-bit destinations take the low byte; unmapped codes leave r untouched
    function automatic regs_t reg_wr(input regs_t r, input logic [3:0] code,
                                     input logic [15:0] v);
        regs_t o;
        o = r;
        case (code)
            REG_D:   begin o.a = v[15:8]; o.b = v[7:0]; end
            REG_X:   o.x  = v;
            REG_Y:   o.y  = v;
            REG_U:   o.u  = v;
            REG_S:   o.s  = v;
            REG_A:   o.a  = v[7:0];
            REG_B:   o.b  = v[7:0];
            REG_CC:  o.cc = v[7:0];
            REG_DP:  o.dp = v[7:0];
            default: o = r;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/jtkcpu_regs_if.sv
// rtl/jtkcpu_regs_if.sv - control/ALU bus between the JTKCPU sequencer/ALU and the register file
//
// master: sequencer/ALU side, drives selects, write strobes, index-step controls and ALU results
// slave : register file, drives opnd0, cc, x/y/u/s, dp and nmi_armed
interface jtkcpu_regs_if;
    logic [3:0]  src_sel;
    logic [3:0]  dst_sel;
    logic        we;
    logic        we_hi;
    logic        we_cc;
    logic        exg;
    logic [1:0]  idx_sel;
    logic        idx_inc;
    logic        idx_dec;
    logic        idx_two;
    logic [15:0] rslt;
    logic [15:0] rslt_hi;
    logic [7:0]  cc_alu;
    logic [15:0] opnd0;
    logic [7:0]  cc;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] u;
    logic [15:0] s;
    logic [7:0]  dp;
    logic        nmi_armed;

    modport master (
        output src_sel, dst_sel, we, we_hi, we_cc, exg,
               idx_sel, idx_inc, idx_dec, idx_two, rslt, rslt_hi, cc_alu,
        input  opnd0, cc, x, y, u, s, dp, nmi_armed
    );

    modport slave (
        input  src_sel, dst_sel, we, we_hi, we_cc, exg,
               idx_sel, idx_inc, idx_dec, idx_two, rslt, rslt_hi, cc_alu,
        output opnd0, cc, x, y, u, s, dp, nmi_armed
    );
endinterface

// File: rtl/jtkcpu_regs_idx_step.sv
// rtl/jtkcpu_regs_idx_step.sv - index register stepper: +/-1 or +/-2 modulo 2^16 on one of X/Y/U/S
//
// Ports:
//   idx_sel   in  2   0 X, 1 Y, 2 U, 3 S
//   idx_inc   in  1   add step
//   idx_dec   in  1   subtract step (both together cancel)
//   idx_two   in  1   step size 2 instead of 1
//   x,y,u,s   in  16  current index register values
//   step_en   out 1   a step is to be written back to idx_sel
//   step_val  out 16  stepped value
module jtkcpu_idx_step (
    input  logic [1:0]  idx_sel,
    input  logic        idx_inc,
    input  logic        idx_dec,
    input  logic        idx_two,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [15:0] u,
    input  logic [15:0] s,
    output logic        step_en,
    output logic [15:0] step_val
);
    logic [15:0] cur;
    logic [15:0] delta;

    always_comb begin
        cur = x;
        case (idx_sel)
            2'd0: cur = x;
            2'd1: cur = y;
            2'd2: cur = u;
            2'd3: cur = s;
            default: cur = x;
        endcase
    end

    assign delta    = idx_two ? 16'd2 : 16'd1;
    assign step_en  = idx_inc ^ idx_dec;
    // wraps naturally in 16 bits
    assign step_val = idx_inc ? (cur + delta) : (cur - delta);

endmodule

// File: rtl/jtkcpu_regs.sv
// rtl/jtkcpu_regs.sv - JTKCPU programmer-visible register file (A,B,X,Y,U,S,DP,CC) with EXG, LMUL writeback and NMI arming
//
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset, honoured regardless of cen
//   cen   in   clock enable qualifying every state update
//   bus   slave modport of jtkcpu_regs_if (selects, strobes, ALU results in;
//         opnd0, cc, x, y, u, s, dp, nmi_armed out)
//
// Build option: define JTKCPU_NMI_ARM_EN to get the NMI arming flop; otherwise
// nmi_armed is constant 1.
module jtkcpu_regs
    import jtkcpu_regs_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    jtkcpu_regs_if.slave  bus
);
    regs_t       cur;
    regs_t       nxt;
    logic        step_en;
    logic [15:0] step_val;
    logic        exg_act;
    logic        we_act;

    jtkcpu_idx_step u_idx_step (
        .idx_sel  (bus.idx_sel),
        .idx_inc  (bus.idx_inc),
        .idx_dec  (bus.idx_dec),
        .idx_two  (bus.idx_two),
        .x        (cur.x),
        .y        (cur.y),
        .u        (cur.u),
        .s        (cur.s),
        .step_en  (step_en),
        .step_val (step_val)
    );

    assign exg_act = bus.exg && (bus.src_sel != bus.dst_sel);
    assign we_act  = bus.we && !bus.exg;

    // Sources are applied lowest priority first so that each later stage
    // overrides earlier ones on any register they share, while untouched
    // registers keep whatever the lower stages put there.
    always_comb begin
        nxt = cur;
        if (bus.we_cc) begin
            nxt.cc = bus.cc_alu;
        end
        if (step_en) begin
            case (bus.idx_sel)
                2'd0: nxt.x = step_val;
                2'd1: nxt.y = step_val;
                2'd2: nxt.u = step_val;
                2'd3: nxt.s = step_val;
                default: nxt.x = step_val;
            endcase
        end
        if (we_act) begin
            nxt = reg_wr(nxt, bus.dst_sel, bus.rslt);
        end
        if (exg_act) begin
            // both sides read the pre-edge values; dst is written last so it
            // wins where src and dst overlap (D against A or B)
            nxt = reg_wr(nxt, bus.src_sel, reg_rd(cur, bus.dst_sel));
            nxt = reg_wr(nxt, bus.dst_sel, reg_rd(cur, bus.src_sel));
        end
        if (bus.we_hi) begin
            nxt.x = bus.rslt_hi;
            nxt.y = bus.rslt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= REGS_RESET;
        end else if (cen) begin
            cur <= nxt;
        end
    end

`ifdef JTKCPU_NMI_ARM_EN
    logic nmi_arm_q;
    logic s_written;

    // index steps on S deliberately do not arm NMI
    assign s_written = (we_act && bus.dst_sel == REG_S) ||
                       (exg_act && (bus.src_sel == REG_S || bus.dst_sel == REG_S));

    always_ff @(posedge clk) begin
        if (rst) begin
            nmi_arm_q <= 1'b0;
        end else if (cen && s_written) begin
            nmi_arm_q <= 1'b1;
        end
    end

    assign bus.nmi_armed = nmi_arm_q;
`else
    assign bus.nmi_armed = 1'b1;
`endif

    assign bus.opnd0 = reg_rd(cur, bus.src_sel);
    assign bus.cc    = cur.cc;
    assign bus.x     = cur.x;
    assign bus.y     = cur.y;
    assign bus.u     = cur.u;
    assign bus.s     = cur.s;
    assign bus.dp    = cur.dp;

endmodule

// File: tb/tb_jtkcpu_regs.sv
// tb/tb_jtkcpu_regs.sv - directed-vector bench for jtkcpu_regs
module tb_jtkcpu_regs;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cen = 1'b1;

    int n_vec = 0;
    int n_bad = 0;

`ifdef JTKCPU_NMI_ARM_EN
    localparam logic NMI_ARMED_EN = 1'b1;
`else
    localparam logic NMI_ARMED_EN = 1'b0;
`endif

    jtkcpu_regs_if bus ();

    jtkcpu_regs dut (
        .clk (clk),
        .rst (rst),
        .cen (cen),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.src_sel = 4'd0;
        bus.dst_sel = 4'd0;
        bus.we      = 1'b0;
        bus.we_hi   = 1'b0;
        bus.we_cc   = 1'b0;
        bus.exg     = 1'b0;
        bus.idx_sel = 2'd0;
        bus.idx_inc = 1'b0;
        bus.idx_dec = 1'b0;
        bus.idx_two = 1'b0;
        bus.rslt    = 16'h0000;
        bus.rslt_hi = 16'h0000;
        bus.cc_alu  = 8'h00;
    endtask

    // one active edge, then settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] dst, input logic [15:0] val);
        idle();
        bus.dst_sel = dst;
        bus.we      = 1'b1;
        bus.rslt    = val;
        tick();
        idle();
    endtask

    task automatic rd(input string tag, input logic [3:0] src, input logic [15:0] exp);
        bus.src_sel = src;
        #1;
        chk(tag, bus.opnd0, exp);
    endtask

    initial begin
        idle();
        #2;
        // reset with state-changing controls active
        rst = 1'b1;
        bus.we = 1'b1; bus.dst_sel = 4'd1; bus.rslt = 16'hFFFF;
        tick();
        rst = 1'b0;
        idle();
        chk("rst_cc", {8'h00, bus.cc}, 16'h0050);
        chk("rst_x", bus.x, 16'h0000);
        chk("rst_y", bus.y, 16'h0000);
        chk("rst_u", bus.u, 16'h0000);
        chk("rst_s", bus.s, 16'h0000);
        chk("rst_dp", {8'h00, bus.dp}, 16'h0000);
        chk("rst_nmi", {15'h0, bus.nmi_armed}, {15'h0, ~NMI_ARMED_EN});

        // D write splits into A:B
        wr(4'd0, 16'h1234);
        rd("rd_a", 4'd8, 16'h0012);
        rd("rd_b", 4'd9, 16'h0034);
        rd("rd_d", 4'd0, 16'h1234);
        rd("rd_unmapped", 4'd5, 16'h0000);

        // S: 0 -> +1 -> 1, then -2 wraps to FFFF without arming NMI
        idle(); bus.idx_sel = 2'd3; bus.idx_inc = 1'b1; tick(); idle();
        chk("s_inc1", bus.s, 16'h0001);
        idle(); bus.idx_sel = 2'd3; bus.idx_dec = 1'b1; bus.idx_two = 1'b1; tick(); idle();
        chk("s_dec2_wrap", bus.s, 16'hFFFF);
        chk("nmi_after_step", {15'h0, bus.nmi_armed}, {15'h0, ~NMI_ARMED_EN});
        wr(4'd4, 16'h8000);
        chk("s_we", bus.s, 16'h8000);
        chk("nmi_after_we", {15'h0, bus.nmi_armed}, 16'h0001);

        // EXG A(F0) <-> X(ABCD), with a we that must be ignored
        wr(4'd8, 16'h00F0);
        wr(4'd1, 16'hABCD);
        idle();
        bus.exg = 1'b1; bus.src_sel = 4'd8; bus.dst_sel = 4'd1;
        bus.we = 1'b1; bus.rslt = 16'h5555;
        tick(); idle();
        rd("exg_a", 4'd8, 16'h00CD);
        chk("exg_x", bus.x, 16'h00F0);
        rd("exg_b_untouched", 4'd9, 16'h0034);

        // EXG with src==dst is a no-op, and its we is still ignored
        idle();
        bus.exg = 1'b1; bus.src_sel = 4'd1; bus.dst_sel = 4'd1;
        bus.we = 1'b1; bus.rslt = 16'h7777;
        tick(); idle();
        chk("exg_self", bus.x, 16'h00F0);

        // LMUL writeback beats an X step
        idle();
        bus.we_hi = 1'b1; bus.rslt_hi = 16'h0001; bus.rslt = 16'h2000;
        bus.idx_sel = 2'd0; bus.idx_inc = 1'b1;
        tick(); idle();
        chk("lmul_x", bus.x, 16'h0001);
        chk("lmul_y", bus.y, 16'h2000);

        // we beats an index step on the same register
        idle();
        bus.we = 1'b1; bus.dst_sel = 4'd2; bus.rslt = 16'h4321;
        bus.idx_sel = 2'd1; bus.idx_dec = 1'b1;
        tick(); idle();
        chk("we_over_step", bus.y, 16'h4321);

        // inc+dec together is a no-op; separate registers update in the same edge
        idle();
        bus.idx_sel = 2'd2; bus.idx_inc = 1'b1; bus.idx_dec = 1'b1;
        bus.we = 1'b1; bus.dst_sel = 4'd11; bus.rslt = 16'h12AB;
        tick(); idle();
        chk("u_incdec", bus.u, 16'h0000);
        chk("dp_low_byte", {8'h00, bus.dp}, 16'h00AB);
        idle(); bus.idx_sel = 2'd2; bus.idx_dec = 1'b1; tick(); idle();
        chk("u_dec1_wrap", bus.u, 16'hFFFF);

        // clock enable low holds everything
        idle();
        cen = 1'b0;
        bus.we = 1'b1; bus.dst_sel = 4'd9; bus.rslt = 16'h00FF;
        tick();
        cen = 1'b1;
        idle();
        rd("cen_hold_b", 4'd9, 16'h0034);

        // we to CC beats we_cc
        idle();
        bus.we = 1'b1; bus.dst_sel = 4'd10; bus.rslt = 16'h0005;
        bus.we_cc = 1'b1; bus.cc_alu = 8'h00;
        tick(); idle();
        chk("cc_we_wins", {8'h00, bus.cc}, 16'h0005);
        idle(); bus.we_cc = 1'b1; bus.cc_alu = 8'hA5; tick(); idle();
        chk("cc_alu", {8'h00, bus.cc}, 16'h00A5);

        // reset mid-EXG and mid-LMUL leaves only reset values
        idle();
        rst = 1'b1;
        bus.exg = 1'b1; bus.src_sel = 4'd10; bus.dst_sel = 4'd4;
        bus.we_hi = 1'b1; bus.rslt_hi = 16'h1111; bus.rslt = 16'h2222;
        tick();
        rst = 1'b0;
        idle();
        chk("rst2_cc", {8'h00, bus.cc}, 16'h0050);
        chk("rst2_s", bus.s, 16'h0000);
        chk("rst2_x", bus.x, 16'h0000);
        chk("rst2_nmi", {15'h0, bus.nmi_armed}, {15'h0, ~NMI_ARMED_EN});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/jtkcpu_regs.md
# jtkcpu_regs

Programmer-visible register file of the JTKCPU core, directly upstream and downstream of the ALU. It drives the ALU's `opnd0` operand and `cc_in` flags. It captures `rslt`, `rslt_hi` and `cc_out` back into the architectural registers. It also performs index-register auto-increment/decrement, stack-pointer stepping, EXG swaps and NMI arming.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset; synchronous, active-high
- `cen`  in  1  clock enable; all state updates are qualified by it
- `src_sel`  in  4  register driven on `opnd0`
- `dst_sel`  in  4  register written by `we`/`exg`
- `we`  in  1  write `rslt` into `dst_sel`
- `we_hi`  in  1  LMUL writeback: `rslt_hi` to X, `rslt` to Y
- `we_cc`  in  1  load CC from `cc_alu`
- `exg`  in  1  swap `src_sel` and `dst_sel` contents
- `idx_sel`  in  2  index register to step: 0 X, 1 Y, 2 U, 3 S
- `idx_inc`  in  1  add step to selected index register
- `idx_dec`  in  1  subtract step from selected index register
- `idx_two`  in  1  step is 2 (else 1)
- `rslt`  in  16  ALU result
- `rslt_hi`  in  16  ALU high result
- `cc_alu`  in  8  ALU `cc_out`
- `opnd0`  out  16  operand to ALU, combinational
- `cc`  out  8  CC register {E,F,H,I,N,Z,V,C}, feeds ALU `cc_in`
- `x`, `y`, `u`, `s`  out  16 each  index registers, for address generation
- `dp`  out  8  direct page register
- `nmi_armed`  out  1  NMI acceptance enabled

## Operation
- Register codes:
  - 16-bit: 0 D (A:B), 1 X, 2 Y, 3 U, 4 S.
  - 8-bit: 8 A, 9 B, 10 CC, 11 DP.
  - Other codes read 0 and ignore writes.
- Reads: `opnd0` = selected register. 8-bit registers are zero-extended.
- Writes with `we`:
  - 16-bit destination takes `rslt[15:0]`.
  - 8-bit destination takes `rslt[7:0]`.
  - D write updates A=`rslt[15:8]`, B=`rslt[7:0]`.
- `we_hi`: X←`rslt_hi`, Y←`rslt` in one cycle. It overrides `we` and index steps to X/Y.
- `we_cc`: CC←`cc_alu`.
- `exg`: dst←old src and src←old dst, in the same edge.
  - 8↔16 mix: the 8-bit side gets the low byte; the 16-bit side gets the zero-extended value.
  - `exg` with src==dst is a no-op.
  - `we` is ignored while `exg` is high.
- Index step: selected register ±1 or ±2, modulo 2^16. `idx_inc` and `idx_dec` together is a no-op.
- Priority on a single register in one edge, highest first: `we_hi` > `exg` > `we` > index step > `we_cc`. Examples:
  - `we` to CC together with `we_cc`: `rslt[7:0]` wins.
  - `we` to X together with an X step: `rslt` wins.
  - Different registers update independently in the same edge.
- NMI arming: `nmi_armed` sets on the first write to S by `we`, `exg` or `we_hi`. Index steps on S do not arm it. It stays set until `rst`.

## Timing
- Reset (synchronous, evaluated regardless of `cen`):
  - A, B, X, Y, U, S, DP = 0.
  - CC = 8'h50 (F and I set).
  - `nmi_armed` = 0.
- `opnd0`: zero latency from `src_sel` and register contents.
- All writes land on the rising `clk` edge with `cen`=1. The new value is visible on outputs the following cycle.
- With `cen`=0, all registers hold. Control inputs are don't-care.
- Register → `opnd0` → ALU → `rslt` → writeback completes in one `cen` cycle. No bypass is needed.
- `rst` asserted mid-EXG or mid-LMUL writeback: reset values win and no partial write remains.

## Configuration
- `JTKCPU_NMI_ARM_EN` defined: arming logic as above.
- `JTKCPU_NMI_ARM_EN` undefined: `nmi_armed` is tied to 1 and the arming flop is removed.

## Structure
- Shared constants go in the shared CPU include, next to the opcode constants:
  - register codes `REG_D` … `REG_DP`
  - CC bit indices `CC_C` … `CC_E`
  - reset CC value
- One sub-module: `jtkcpu_idx_step`, the ±1/±2 modulo-16-bit stepper selecting one of X/Y/U/S.

## Test plan
- Reset: apply `rst` one cycle → `cc`=8'h50; X=Y=U=S=0; DP=0; `nmi_armed`=0.
- `we`, `dst_sel`=D, `rslt`=16'h1234 → A=8'h12, B=8'h34; then `src_sel`=A → `opnd0`=16'h0012.
- `idx_sel`=S, `idx_dec`, `idx_two` with S=16'h0001 → S=16'hFFFF; `nmi_armed` stays 0. Then `we` S=16'h8000 → `nmi_armed`=1.
- `exg` src=A(8'hF0), dst=X(16'hABCD) → A=8'hCD, X=16'h00F0.
- `we_hi`, `rslt_hi`=16'h0001, `rslt`=16'h2000, with `idx_inc` on X the same cycle → X=16'h0001, Y=16'h2000.
- `cen`=0 with `we`, `dst_sel`=B, `rslt`=16'h00FF → B unchanged. Then `cen`=1 with `we` to CC plus `we_cc` (`cc_alu`=8'h00), `rslt`=16'h0005 → `cc`=8'h05.
